// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg
//   Shared ISA definitions for the instruction loader and decoder: opcode and
//   funct codes, instruction field bit positions, the instruction format
//   classification helper and the loader FSM state type.
//   Keeping field positions here means the decoder and loader cannot diverge.
package inst_loader_pkg;

  // Opcodes; 7..F are illegal.
  typedef enum logic [3:0] {
    OP_R_TYPE = 4'h0,
    OP_LDR    = 4'h1,
    OP_STR    = 4'h2,
    OP_ADDI   = 4'h3,
    OP_SUBI   = 4'h4,
    OP_BNE    = 4'h5,
    OP_JMP    = 4'h6
  } opcode_e;

  // R-type funct codes. The loader passes funct through unchecked.
  localparam logic [7:0] FN_ADD  = 8'h00;
  localparam logic [7:0] FN_SUB  = 8'h01;
  localparam logic [7:0] FN_SUBS = 8'h02;
  localparam logic [7:0] FN_AND  = 8'h03;
  localparam logic [7:0] FN_OR   = 8'h04;

  // Instruction field bit positions within the 18-bit word.
  localparam int unsigned OPC_MSB   = 17;
  localparam int unsigned OPC_LSB   = 14;
  localparam int unsigned RD_MSB    = 13;
  localparam int unsigned RD_LSB    = 12;
  localparam int unsigned RS1_MSB   = 11;
  localparam int unsigned RS1_LSB   = 10;
  localparam int unsigned RS2_MSB   = 9;
  localparam int unsigned RS2_LSB   = 8;
  localparam int unsigned FUNCT_MSB = 7;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMMI_MSB  = 7;
  localparam int unsigned IMMI_LSB  = 0;
  localparam int unsigned IMMJ_MSB  = 13;
  localparam int unsigned IMMJ_LSB  = 0;

  // Encoding format selected by an opcode.
  typedef enum logic [1:0] {
    FMT_R       = 2'd0,
    FMT_I       = 2'd1,
    FMT_J       = 2'd2,
    FMT_ILLEGAL = 2'd3
  } fmt_e;

  // Loader session states. FLUSH covers the cycle in which the final word
  // is on the write port, so DONE lands one cycle after the last write.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic fmt_e opcode_format(input logic [3:0] op);
    fmt_e fmt;
    case (op)
      OP_R_TYPE:                        fmt = FMT_R;
      OP_LDR, OP_STR, OP_ADDI, OP_SUBI: fmt = FMT_I;
      OP_BNE, OP_JMP:                   fmt = FMT_J;
      default:                          fmt = FMT_ILLEGAL;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/inst_loader_if.sv
// inst_loader_if
//   Host-side bundle handshake, session control/status and instruction
//   memory write port of the loader, grouped in one interface.
//   master : host / program source (drives i_*, observes o_*)
//   slave  : inst_loader (observes i_*, drives o_*)
//   Signals:
//     i_start, i_base_addr         start a session at a base address
//     i_valid, o_ready, i_last     field bundle handshake
//     i_opcode, i_rd, i_rs1, i_rs2, i_funct, i_imm   instruction fields
//     o_imem_we, o_imem_addr, o_imem_wdata           registered write port
//     o_busy, o_done, o_err, o_word_count            session status
interface inst_loader_if #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned INST_WIDTH     = 18,
  parameter int unsigned OPCODE_WIDTH   = 4,
  parameter int unsigned FUNCTION_WIDTH = 8
);
  logic                      i_start;
  logic [ADDR_WIDTH-1:0]     i_base_addr;
  logic                      i_valid;
  logic                      o_ready;
  logic                      i_last;
  logic [OPCODE_WIDTH-1:0]   i_opcode;
  logic [1:0]                i_rd;
  logic [1:0]                i_rs1;
  logic [1:0]                i_rs2;
  logic [FUNCTION_WIDTH-1:0] i_funct;
  logic [13:0]               i_imm;
  logic                      o_imem_we;
  logic [ADDR_WIDTH-1:0]     o_imem_addr;
  logic [INST_WIDTH-1:0]     o_imem_wdata;
  logic                      o_busy;
  logic                      o_done;
  logic                      o_err;
  logic [ADDR_WIDTH:0]       o_word_count;

  modport master (
    output i_start, i_base_addr, i_valid, i_last,
    output i_opcode, i_rd, i_rs1, i_rs2, i_funct, i_imm,
    input  o_ready, o_imem_we, o_imem_addr, o_imem_wdata,
    input  o_busy, o_done, o_err, o_word_count
  );

  modport slave (
    input  i_start, i_base_addr, i_valid, i_last,
    input  i_opcode, i_rd, i_rs1, i_rs2, i_funct, i_imm,
    output o_ready, o_imem_we, o_imem_addr, o_imem_wdata,
    output o_busy, o_done, o_err, o_word_count
  );
endinterface

// File: rtl/inst_loader_encode.sv
// inst_encode
//   Combinational field packer: builds an instruction word from its fields
//   and flags opcodes that have no encoding.
//   Ports:
//     opcode_i, rd_i, rs1_i, rs2_i, funct_i, imm_i  instruction fields
//     word_o     packed instruction word (all zero when illegal)
//     illegal_o  opcode has no defined format
//   Fields unused by the selected format are ignored; I-type takes imm[7:0],
//   J-type takes imm[13:0], and I-type bits [9:8] are always zero.
module inst_encode
  import inst_loader_pkg::*;
#(
  parameter int unsigned INST_WIDTH     = 18,
  parameter int unsigned OPCODE_WIDTH   = 4,
  parameter int unsigned FUNCTION_WIDTH = 8
) (
  input  logic [OPCODE_WIDTH-1:0]   opcode_i,
  input  logic [1:0]                rd_i,
  input  logic [1:0]                rs1_i,
  input  logic [1:0]                rs2_i,
  input  logic [FUNCTION_WIDTH-1:0] funct_i,
  input  logic [13:0]               imm_i,
  output logic [INST_WIDTH-1:0]     word_o,
  output logic                      illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    unique case (opcode_format(opcode_i))
      FMT_R: begin
        word_o[OPC_MSB:OPC_LSB]     = opcode_i;
        word_o[RD_MSB:RD_LSB]       = rd_i;
        word_o[RS1_MSB:RS1_LSB]     = rs1_i;
        word_o[RS2_MSB:RS2_LSB]     = rs2_i;
        word_o[FUNCT_MSB:FUNCT_LSB] = funct_i;
      end
      FMT_I: begin
        word_o[OPC_MSB:OPC_LSB]   = opcode_i;
        word_o[RD_MSB:RD_LSB]     = rd_i;
        word_o[RS1_MSB:RS1_LSB]   = rs1_i;
        word_o[IMMI_MSB:IMMI_LSB] = imm_i[IMMI_MSB:IMMI_LSB];
      end
      FMT_J: begin
        word_o[OPC_MSB:OPC_LSB]   = opcode_i;
        word_o[IMMJ_MSB:IMMJ_LSB] = imm_i[IMMJ_MSB:IMMJ_LSB];
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_loader.sv
// inst_loader
//   Writer-side counterpart of the instruction decoder. Accepts instruction
//   field bundles over a valid/ready handshake, packs them into instruction
//   words and writes them to consecutive instruction memory addresses
//   through a registered write port.
//   Ports:
//     i_clk  clock
//     i_rst  asynchronous active-high reset
//     bus    inst_loader_if.slave: start/base address, bundle handshake and
//            fields, imem write port, busy/done/err/word count status
//   Session: IDLE -(i_start)-> LOAD -(last/overflow)-> FLUSH -> DONE -> IDLE,
//   or LOAD -(illegal opcode)-> DONE directly since nothing is written.
//   o_err is sticky until the next accepted i_start (or reset).
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned INST_WIDTH     = 18,
  parameter int unsigned OPCODE_WIDTH   = 4,
  parameter int unsigned FUNCTION_WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  inst_loader_if.slave  bus
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic                    err_q, err_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [INST_WIDTH-1:0]   wdata_q, wdata_d;

  logic [INST_WIDTH-1:0]   enc_word;
  logic                    enc_illegal;

  inst_encode #(
    .INST_WIDTH     (INST_WIDTH),
    .OPCODE_WIDTH   (OPCODE_WIDTH),
    .FUNCTION_WIDTH (FUNCTION_WIDTH)
  ) u_encode (
    .opcode_i  (bus.i_opcode),
    .rd_i      (bus.i_rd),
    .rs1_i     (bus.i_rs1),
    .rs2_i     (bus.i_rs2),
    .funct_i   (bus.i_funct),
    .imm_i     (bus.i_imm),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d = ST_LOAD;
          addr_d  = bus.i_base_addr;
          count_d = '0;
          err_d   = 1'b0;
        end
      end

      ST_LOAD: begin
        // o_ready is 1 throughout LOAD, so i_valid alone means accepted.
        if (bus.i_valid) begin
          if (enc_illegal) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = enc_word;
            addr_d  = addr_q + ADDR_WIDTH'(1);
            count_d = count_q + (ADDR_WIDTH+1)'(1);
            if (bus.i_last) begin
              state_d = ST_FLUSH;
            end else if (addr_q == '1) begin
              // Top of memory reached with more words to come: the session
              // ends here instead of wrapping onto address 0.
              err_d   = 1'b1;
              state_d = ST_FLUSH;
            end
          end
        end
      end

      ST_FLUSH: begin
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.o_ready      = (state_q == ST_LOAD);
  assign bus.o_busy       = (state_q != ST_IDLE);
  assign bus.o_done       = (state_q == ST_DONE);
  assign bus.o_err        = err_q;
  assign bus.o_word_count = count_q;
  assign bus.o_imem_we    = we_q;
  assign bus.o_imem_addr  = waddr_q;
  assign bus.o_imem_wdata = wdata_q;

  // A write is always the cycle after an accept, so the session is still live.
  a_we_in_session: assert property (@(posedge i_clk) disable iff (i_rst)
    we_q |-> (state_q == ST_LOAD || state_q == ST_FLUSH));

  a_done_single_cycle: assert property (@(posedge i_clk) disable iff (i_rst)
    (state_q == ST_DONE) |=> (state_q == ST_IDLE));

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  rd;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic [7:0]  funct;
    logic [13:0] imm;
    logic        last;
    int unsigned gap;
  } bundle_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_loader_if #(.ADDR_WIDTH(8), .INST_WIDTH(18), .OPCODE_WIDTH(4), .FUNCTION_WIDTH(8)) bus();

  inst_loader #(.ADDR_WIDTH(8), .INST_WIDTH(18), .OPCODE_WIDTH(4), .FUNCTION_WIDTH(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor (sampled mid-cycle).
  logic [7:0]  w_addr[$];
  logic [17:0] w_data[$];
  int unsigned w_cyc[$];
  int unsigned done_total = 0;
  int unsigned done_cyc = 0;
  logic [8:0]  done_count = '0;
  logic        done_err = 1'b0;

  always @(negedge clk) begin
    if (bus.o_imem_we === 1'b1) begin
      w_addr.push_back(bus.o_imem_addr);
      w_data.push_back(bus.o_imem_wdata);
      w_cyc.push_back(cyc);
    end
    if (bus.o_done === 1'b1) begin
      done_total = done_total + 1;
      done_cyc   = cyc;
      done_count = bus.o_word_count;
      done_err   = bus.o_err;
    end
  end

  bundle_t prog[$];
  int unsigned sess_wb;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fields(input bundle_t b);
    bus.i_opcode = b.op;
    bus.i_rd     = b.rd;
    bus.i_rs1    = b.rs1;
    bus.i_rs2    = b.rs2;
    bus.i_funct  = b.funct;
    bus.i_imm    = b.imm;
    bus.i_last   = b.last;
  endtask

  function automatic bundle_t mk(input int op, input int rd, input int rs1, input int rs2,
                                 input int funct, input int imm, input bit last, input int gap);
    bundle_t b;
    b.op = 4'(op); b.rd = 2'(rd); b.rs1 = 2'(rs1); b.rs2 = 2'(rs2);
    b.funct = 8'(funct); b.imm = 14'(imm); b.last = last; b.gap = gap;
    return b;
  endfunction

  function automatic bundle_t rand_bundle(input bit allow_illegal);
    int op;
    if (allow_illegal && $urandom_range(0, 9) == 0) op = int'($urandom_range(7, 15));
    else op = int'($urandom_range(0, 6));
    return mk(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 16383)), 1'b0,
              int'($urandom_range(0, 2)));
  endfunction

  // Reference encoding from the format rules, in plain arithmetic.
  function automatic logic [17:0] ref_word(input bundle_t b);
    int w;
    int op;
    op = int'(b.op);
    if (op == 0)
      w = op * 16384 + int'(b.rd) * 4096 + int'(b.rs1) * 1024 + int'(b.rs2) * 256 + int'(b.funct);
    else if (op <= 4)
      w = op * 16384 + int'(b.rd) * 4096 + int'(b.rs1) * 1024 + (int'(b.imm) % 256);
    else
      w = op * 16384 + int'(b.imm);
    return 18'(w);
  endfunction

  // Runs prog as one session starting at base; checks against the model.
  task automatic run_session(input logic [7:0] base, input bit start_noise);
    int          a;
    int unsigned exp_n_acc;
    logic [7:0]  e_addr[$];
    logic [17:0] e_data[$];
    bit          e_err;
    bit          e_illegal_end;
    int          e_count;
    int unsigned db;
    int unsigned acc;
    int unsigned acc_cyc[$];
    int unsigned tries;
    int unsigned nw;

    a = int'(base); exp_n_acc = 0; e_err = 0; e_illegal_end = 0; e_count = 0;
    foreach (prog[i]) begin
      exp_n_acc++;
      if (prog[i].op > 4'd6) begin e_err = 1; e_illegal_end = 1; break; end
      e_addr.push_back(8'(a));
      e_data.push_back(ref_word(prog[i]));
      e_count++;
      if (prog[i].last) break;
      if (a == 255) begin e_err = 1; break; end
      a++;
    end

    sess_wb = w_addr.size();
    db = done_total;

    bus.i_base_addr = base;
    bus.i_start = 1'b1;
    cycle();
    bus.i_start = 1'b0;
    bus.i_base_addr = 8'($urandom);

    checks++; if (bus.o_busy !== 1'b1) $display("FAIL start_busy: got %b want 1", bus.o_busy); else passed++;
    checks++; if (bus.o_word_count !== 9'd0) $display("FAIL start_count: got %0d want 0", bus.o_word_count); else passed++;
    checks++; if (bus.o_err !== 1'b0) $display("FAIL start_err_clear: got %b want 0", bus.o_err); else passed++;

    acc = 0;
    foreach (prog[i]) begin
      for (int unsigned g = 0; g < prog[i].gap; g++) begin
        bus.i_valid = 1'b0;
        drive_fields(rand_bundle(1'b1));
        if (start_noise && i < int'(exp_n_acc)) begin
          bus.i_start = 1'b1;
          bus.i_base_addr = 8'($urandom);
        end
        cycle();
        bus.i_start = 1'b0;
      end
      drive_fields(prog[i]);
      bus.i_valid = 1'b1;
      tries = 0;
      while (bus.o_ready !== 1'b1 && tries < 8) begin
        cycle();
        tries++;
      end
      if (bus.o_ready !== 1'b1) break;
      cycle();
      acc++;
      acc_cyc.push_back(cyc);
      if (acc == exp_n_acc) begin
        checks++; if (bus.o_ready !== 1'b0) $display("FAIL ready_drop: got %b want 0", bus.o_ready); else passed++;
      end
    end
    bus.i_valid = 1'b0;

    tries = 0;
    while (done_total == db && tries < 20) begin
      cycle();
      tries++;
    end
    cycle();

    nw = w_addr.size() - sess_wb;
    checks++; if (acc !== exp_n_acc) $display("FAIL accepted: got %0d want %0d", acc, exp_n_acc); else passed++;
    checks++; if (done_total - db !== 1) $display("FAIL done_pulses: got %0d want 1", done_total - db); else passed++;
    checks++; if (nw !== e_addr.size()) $display("FAIL write_count: got %0d want %0d", nw, e_addr.size()); else passed++;
    if (nw == e_addr.size() && acc == exp_n_acc) begin
      foreach (e_addr[k]) begin
        checks++;
        if (w_addr[sess_wb + k] !== e_addr[k] || w_data[sess_wb + k] !== e_data[k])
          $display("FAIL write[%0d]: got %h@%h want %h@%h", k, w_data[sess_wb + k], w_addr[sess_wb + k], e_data[k], e_addr[k]);
        else passed++;
        checks++;
        if (w_cyc[sess_wb + k] !== acc_cyc[k])
          $display("FAIL write_latency[%0d]: got cycle %0d want %0d", k, w_cyc[sess_wb + k], acc_cyc[k]);
        else passed++;
      end
      checks++;
      if (e_illegal_end) begin
        if (done_cyc !== acc_cyc[acc - 1]) $display("FAIL done_timing_illegal: got cycle %0d want %0d", done_cyc, acc_cyc[acc - 1]);
        else passed++;
      end else begin
        if (done_cyc !== w_cyc[w_cyc.size() - 1] + 1) $display("FAIL done_timing: got cycle %0d want %0d", done_cyc, w_cyc[w_cyc.size() - 1] + 1);
        else passed++;
      end
    end
    checks++; if (done_err !== e_err) $display("FAIL done_err: got %b want %b", done_err, e_err); else passed++;
    checks++; if (done_count !== 9'(e_count)) $display("FAIL done_count: got %0d want %0d", done_count, e_count); else passed++;
    checks++; if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) $display("FAIL idle_after: busy %b done %b want 0 0", bus.o_busy, bus.o_done); else passed++;
    checks++; if (bus.o_err !== e_err) $display("FAIL err_sticky: got %b want %b", bus.o_err, e_err); else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    checks++;
    if (bus.o_imem_we !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_err !== 1'b0 ||
        bus.o_ready !== 1'b0 || bus.o_word_count !== 9'd0 || bus.o_imem_addr !== 8'd0 || bus.o_imem_wdata !== 18'd0)
      $display("FAIL reset_outputs: we%b busy%b done%b err%b rdy%b cnt%0d addr%h data%h want all 0",
               bus.o_imem_we, bus.o_busy, bus.o_done, bus.o_err, bus.o_ready, bus.o_word_count,
               bus.o_imem_addr, bus.o_imem_wdata);
    else passed++;
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_addi_single();
    prog.delete();
    prog.push_back(mk(3, 1, 2, 0, 0, 5, 1'b1, 0));
    run_session(8'h00, 1'b0);
    checks++;
    if (w_data.size() <= sess_wb) $display("FAIL addi_word: got no write want 0d805@00");
    else if (w_data[sess_wb] !== 18'h0D805 || w_addr[sess_wb] !== 8'h00)
      $display("FAIL addi_word: got %h@%h want 0d805@00", w_data[sess_wb], w_addr[sess_wb]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    prog.delete();
    prog.push_back(mk(0, 3, 1, 2, 8'h01, 0, 1'b0, 0));
    prog.push_back(mk(6, 0, 0, 0, 0, 14'h3FFF, 1'b1, 0));
    run_session(8'h10, 1'b0);
    checks++;
    if (w_data.size() < sess_wb + 2) $display("FAIL b2b_words: got %0d writes want 2", w_data.size() - sess_wb);
    else if (w_data[sess_wb] !== 18'h03601 || w_addr[sess_wb] !== 8'h10 ||
             w_data[sess_wb + 1] !== 18'h1BFFF || w_addr[sess_wb + 1] !== 8'h11 ||
             w_cyc[sess_wb + 1] !== w_cyc[sess_wb] + 1)
      $display("FAIL b2b_words: got %h@%h %h@%h gap %0d want 03601@10 1bfff@11 gap 1",
               w_data[sess_wb], w_addr[sess_wb], w_data[sess_wb + 1], w_addr[sess_wb + 1],
               w_cyc[sess_wb + 1] - w_cyc[sess_wb]);
    else passed++;
  endtask

  task automatic test_illegal();
    prog.delete();
    prog.push_back(mk(1, 2, 3, 0, 0, 8'h7A, 1'b0, 0));
    prog.push_back(mk(15, 1, 1, 1, 0, 0, 1'b0, 0));
    prog.push_back(mk(3, 1, 1, 0, 0, 1, 1'b1, 0));
    run_session(8'h40, 1'b0);
    checks++;
    if (w_addr.size() - sess_wb !== 1) $display("FAIL illegal_writes: got %0d want 1", w_addr.size() - sess_wb);
    else passed++;
  endtask

  task automatic test_overflow();
    bit hit_zero;
    prog.delete();
    for (int i = 0; i < 3; i++) prog.push_back(mk(3, i, 1, 0, 0, i + 1, 1'b0, 0));
    run_session(8'hFE, 1'b0);
    hit_zero = 1'b0;
    for (int unsigned k = sess_wb; k < w_addr.size(); k++) if (w_addr[k] == 8'h00) hit_zero = 1'b1;
    checks++;
    if (hit_zero) $display("FAIL overflow_no_wrap: got write to 00 want none"); else passed++;
  endtask

  task automatic test_reset_mid();
    int unsigned wb;
    checks++; if (bus.o_err !== 1'b1) $display("FAIL err_before_reset: got %b want 1", bus.o_err); else passed++;
    bus.i_base_addr = 8'h20;
    bus.i_start = 1'b1;
    cycle();
    bus.i_start = 1'b0;
    drive_fields(mk(4, 1, 1, 0, 0, 9, 1'b0, 0));
    bus.i_valid = 1'b1;
    cycle();
    bus.i_valid = 1'b0;
    wb = w_addr.size();
    checks++; if (bus.o_imem_we !== 1'b1) $display("FAIL pre_reset_write: got we %b want 1", bus.o_imem_we); else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_imem_we !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_err !== 1'b0 || bus.o_ready !== 1'b0 || bus.o_word_count !== 9'd0)
      $display("FAIL reset_mid: we%b busy%b err%b rdy%b cnt%0d want all 0",
               bus.o_imem_we, bus.o_busy, bus.o_err, bus.o_ready, bus.o_word_count);
    else passed++;
    cycle();
    rst = 1'b0;
    cycle();
    checks++; if (w_addr.size() !== wb) $display("FAIL reset_no_write: got %0d writes want 0", w_addr.size() - wb); else passed++;
    prog.delete();
    prog.push_back(mk(2, 0, 3, 0, 0, 8'hC3, 1'b0, 0));
    prog.push_back(mk(5, 0, 0, 0, 0, 14'h1234, 1'b1, 0));
    run_session(8'h30, 1'b0);
  endtask

  task automatic test_gaps_start();
    prog.delete();
    for (int i = 0; i < 5; i++) begin
      prog.push_back(rand_bundle(1'b0));
      prog[i].gap = $urandom_range(1, 3);
    end
    prog[4].last = 1'b1;
    run_session(8'h80, 1'b1);
  endtask

  task automatic test_random();
    int n;
    logic [7:0] base;
    for (int s = 0; s < 25; s++) begin
      prog.delete();
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) prog.push_back(rand_bundle(1'b1));
      prog[n - 1].last = 1'b1;
      if ($urandom_range(0, 3) == 0) base = 8'(256 - int'($urandom_range(1, 4)));
      else base = 8'($urandom);
      run_session(base, s[0]);
    end
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_base_addr = '0; bus.i_valid = 1'b0; bus.i_last = 1'b0;
    bus.i_opcode = '0; bus.i_rd = '0; bus.i_rs1 = '0; bus.i_rs2 = '0; bus.i_funct = '0; bus.i_imm = '0;
    #2;
    test_reset();
    test_addi_single();
    test_back_to_back();
    test_illegal();
    test_overflow();
    test_reset_mid();
    test_gaps_start();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Writer-side counterpart of the instruction decoder: packs instruction fields (opcode, registers, funct, immediate) into 18-bit instruction words. Writes the words sequentially into instruction memory through a registered write port. Sits between the testbench/host program source and the instruction memory, so programs are built from fields rather than hand-assembled hex. Runs a start/load/done state machine with a valid/ready input handshake, an address counter, and illegal-opcode and overflow error detection.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction memory address width
- INST_WIDTH, 18, instruction word width
- OPCODE_WIDTH, 4, opcode field width
- FUNCTION_WIDTH, 8, R-type funct field width

Ports:
- One clock, `i_clk`; reset `i_rst` is asynchronous and active-high.
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_start  in  1  begin a load session (honoured in IDLE only)
- i_base_addr  in  ADDR_WIDTH  first write address, sampled with i_start
- i_valid  in  1  field bundle valid
- o_ready  out  1  loader accepts a bundle this cycle
- i_last  in  1  bundle is the final instruction of the session
- i_opcode  in  4  opcode
- i_rd, i_rs1, i_rs2  in  2 each  register fields
- i_funct  in  8  R-type function code
- i_imm  in  14  immediate; I-type uses [7:0], J-type uses [13:0]
- o_imem_we  out  1  instruction memory write strobe
- o_imem_addr  out  ADDR_WIDTH  write address
- o_imem_wdata  out  18  encoded word
- o_busy  out  1  session in progress
- o_done  out  1  one-cycle end-of-session pulse
- o_err  out  1  session aborted; sticky until next accepted i_start
- o_word_count  out  ADDR_WIDTH+1  words written this session

## Operation
- Opcodes: R_TYPE=0, LDR=1, STR=2, ADDI=3, SUBI=4, BNE=5, JMP=6.
- Funct codes: ADD=00, SUB=01, SUBS=02, AND=03, OR=04 (hex). Opcodes 7–F are illegal.
- Encoding formats, all with opcode in [17:14]:
  - R: rd[13:12], rs1[11:10], rs2[9:8], funct[7:0].
  - I (LDR/STR/ADDI/SUBI): rd[13:12], rs1[11:10], [9:8]=0, imm[7:0].
  - J (BNE/JMP): imm[13:0].
  - Unused input fields are ignored. Funct is passed through unchecked.
- IDLE: o_ready=0. On i_start → LOAD; set addr=i_base_addr, count=0, clear o_err.
- LOAD: o_ready=1 unless the session end is pending. A bundle is accepted on i_valid&&o_ready.
  - Legal opcode: word is written; addr increments mod 2^ADDR_WIDTH; count increments.
  - Illegal opcode: nothing is written; o_err=1; → DONE.
  - Accepted with i_last: written; → DONE.
  - Accepted at addr 2^ADDR_WIDTH−1 without i_last: written; o_err=1; → DONE. The address never wraps within a session.
- DONE: o_done=1 for one cycle → IDLE.
- i_start outside IDLE is ignored.
- Reset mid-session: everything clears immediately; no further write is issued.
- Reset values: all outputs 0, state IDLE.

## Timing
- Accept in cycle N → o_imem_we/addr/wdata valid in N+1 for exactly one cycle (registered).
- Throughput is one word per cycle.
- o_ready drops in the cycle after accepting a terminating bundle.
- o_done is asserted in the cycle after the final write, or the cycle after an illegal-opcode accept.
- o_busy=1 from the cycle after i_start through the o_done cycle.

## Structure
- Opcode and funct codes live in `opcode_defs.vh`.
- Field bit positions (OPC_MSB/LSB, RD_*, RS1_*, RS2_*, FUNCT_*, IMMI_*, IMMJ_*) go in a new shared `isa_fields.vh` so the decoder and loader cannot diverge.
- FSM state encodings are local parameters.
- One combinational sub-module, `inst_encode` (fields → word plus illegal flag); the FSM and write register stay in the top module.

## Test plan
- Reset, start base=00, ADDI rd=1 rs1=2 imm=05 last=1 → next cycle we=1, addr=00, wdata=18'h0D805; then o_done, count=1, o_err=0.
- R-type SUB rd=3 rs1=1 rs2=2 funct=01, then JMP imm=3FFF last, back-to-back at base=10 → writes 18'h03601@10 and 18'h1BFFF@11 in consecutive cycles.
- Opcode F mid-session after one good word → no write for F, o_err=1, o_done pulse, count=1.
- base=FE, three non-last ADDI words → writes at FE and FF only, o_ready drops, o_err=1, no write to 00.
- Gaps in i_valid and i_start asserted during LOAD → no spurious writes, addresses contiguous, session unaffected.
- i_rst asserted the cycle after an accept → o_imem_we=0, o_busy=0, o_err=0 immediately; a following i_start works normally.
